// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset
// polarity, the bubble instruction and word-alignment helpers.
package stage_if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_OUT  = 2'b11
    } if_state_t;

    localparam logic        RESET_ACTIVE_N = 1'b0;
    localparam logic [31:0] INST_NOP       = 32'h0000_0000;
    localparam logic [31:0] PC_STEP        = 32'd4;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time and presents the fetched word plus its PC to decode.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_write_enable,
    input  logic [31:0] pc_write_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        instruction_valid,
    output logic        misalign_error,
    output if_state_t   fsm_state
);

    // Handshake: a request transfers on a cycle where imem_req and imem_ready
    // are both high; imem_req/imem_addr depend only on state, so they stay
    // stable until that transfer. A response is consumed only in S_WAIT when
    // imem_rvalid is high.

    if_state_t   state;
    logic [31:0] fetch_pc;

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ACTIVE_N) begin
            state             <= S_IDLE;
            fetch_pc          <= RESET_PC;
            instruction_o     <= INST_NOP;
            pc_o              <= RESET_PC;
            instruction_valid <= 1'b0;
            misalign_error    <= 1'b0;
        end else begin
            misalign_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instruction_o     <= imem_rdata;
                        pc_o              <= fetch_pc;
                        instruction_valid <= 1'b1;
                        state             <= S_OUT;
                    end
                end
                S_OUT: begin
                    // A stall freezes everything, including a pending redirect,
                    // which decode keeps driving until the stall clears.
                    if (!stall) begin
                        if (pc_write_enable) begin
                            fetch_pc       <= align_word(pc_write_data);
                            misalign_error <= is_misaligned(pc_write_data);
                        end else begin
                            fetch_pc <= pc_o + PC_STEP;
                        end
                        instruction_o     <= INST_NOP;
                        instruction_valid <= 1'b0;
                        state             <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = fetch_pc;
        fsm_state = state;
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: sequential fetch, memory back-pressure,
// redirects, stall priority, misalignment, PC wrap and mid-transaction reset.
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        pc_write_enable = 1'b0;
    logic [31:0] pc_write_data = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        instruction_valid;
    logic        misalign_error;
    if_state_t   fsm_state;

    int vectors = 0;
    int fails   = 0;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .pc_write_enable   (pc_write_enable),
        .pc_write_data     (pc_write_data),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .instruction_o     (instruction_o),
        .pc_o              (pc_o),
        .instruction_valid (instruction_valid),
        .misalign_error    (misalign_error),
        .fsm_state         (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_inst"},  instruction_o, 32'h0);
        check({tag, "_pc"},    pc_o, 32'h0);
        check({tag, "_valid"}, {31'h0, instruction_valid}, 32'h0);
        check({tag, "_mis"},   {31'h0, misalign_error}, 32'h0);
        check({tag, "_state"}, {30'h0, fsm_state}, {30'h0, S_IDLE});
    endtask

    // Starts in S_REQ; accepts the request at once, answers one cycle later,
    // and ends with the instruction presented in S_OUT.
    task automatic do_fetch(input string tag, input logic [31:0] addr_exp, input logic [31:0] data);
        check({tag, "_req"},  {31'h0, imem_req}, 32'h1);
        check({tag, "_addr"}, imem_addr, addr_exp);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check({tag, "_req_drop"}, {31'h0, imem_req}, 32'h0);
        check({tag, "_wait_valid"}, {31'h0, instruction_valid}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check({tag, "_valid"}, {31'h0, instruction_valid}, 32'h1);
        check({tag, "_inst"},  instruction_o, data);
        check({tag, "_pc"},    pc_o, addr_exp);
    endtask

    // Leaves S_OUT without redirect and checks the bubble and next address.
    task automatic advance(input string tag, input logic [31:0] next_addr);
        tick();
        check({tag, "_bubble_valid"}, {31'h0, instruction_valid}, 32'h0);
        check({tag, "_bubble_inst"},  instruction_o, 32'h0);
        check({tag, "_next_addr"},    imem_addr, next_addr);
    endtask

    initial begin
        int waited;

        // Reset state
        tick();
        tick();
        check_reset_values("reset");

        // Release reset and wait (bounded) for the first request.
        reset = 1'b1;
        waited = 0;
        while (!imem_req && waited < 4) begin
            tick();
            waited++;
        end
        check("first_req_seen", {31'h0, imem_req}, 32'h1);

        // Sequential fetch: 0, 4, 8 with one instruction every three cycles.
        do_fetch("f0", 32'h0, 32'hA000_0000);
        advance("f0", 32'h4);

        // Back-pressure: address stable, redirect ignored outside S_OUT.
        pc_write_enable = 1'b1;
        pc_write_data   = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_req",   {31'h0, imem_req}, 32'h1);
            check("hold_addr",  imem_addr, 32'h4);
            check("hold_valid", {31'h0, instruction_valid}, 32'h0);
        end
        pc_write_enable = 1'b0;
        pc_write_data   = 32'h0;
        do_fetch("f4", 32'h4, 32'hA000_0004);
        advance("f4", 32'h8);
        do_fetch("f8", 32'h8, 32'hA000_0008);
        advance("f8", 32'hC);
        do_fetch("fc", 32'hC, 32'hA000_000C);
        advance("fc", 32'h10);
        do_fetch("f10", 32'h10, 32'hA000_0010);

        // Jump from 0x10 to 0x40; 0x14 must not be requested.
        pc_write_enable = 1'b1;
        pc_write_data   = 32'h40;
        tick();
        pc_write_enable = 1'b0;
        check("jump_addr", imem_addr, 32'h40);
        check("jump_mis",  {31'h0, misalign_error}, 32'h0);
        do_fetch("f40", 32'h40, 32'hA000_0040);

        // Stall with a pending redirect: outputs held, redirect deferred.
        stall           = 1'b1;
        pc_write_enable = 1'b1;
        pc_write_data   = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'h0, instruction_valid}, 32'h1);
            check("stall_inst",  instruction_o, 32'hA000_0040);
            check("stall_pc",    pc_o, 32'h40);
            check("stall_req",   {31'h0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        tick();
        pc_write_enable = 1'b0;
        check("unstall_addr",  imem_addr, 32'h80);
        check("unstall_valid", {31'h0, instruction_valid}, 32'h0);
        do_fetch("f80", 32'h80, 32'hA000_0080);

        // Misaligned redirect: aligned address plus a single-cycle pulse.
        pc_write_enable = 1'b1;
        pc_write_data   = 32'h43;
        tick();
        pc_write_enable = 1'b0;
        check("mis_addr",  imem_addr, 32'h40);
        check("mis_pulse", {31'h0, misalign_error}, 32'h1);
        tick();
        check("mis_clear", {31'h0, misalign_error}, 32'h0);
        do_fetch("f40b", 32'h40, 32'h1234_5678);

        // PC wrap at the top of the address space.
        pc_write_enable = 1'b1;
        pc_write_data   = 32'hFFFF_FFFC;
        tick();
        pc_write_enable = 1'b0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch("ftop", 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        advance("ftop", 32'h0);

        // Reset while waiting for a response; stray data must be dropped.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("pre_reset_state", {30'h0, fsm_state}, {30'h0, S_WAIT});
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        check_reset_values("in_reset");
        reset = 1'b1;
        tick();
        check("post_reset_valid", {31'h0, instruction_valid}, 32'h0);
        check("post_reset_inst",  instruction_o, 32'h0);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        waited = 0;
        while (!imem_req && waited < 4) begin
            tick();
            waited++;
        end
        do_fetch("f_rst", 32'h0, 32'hA000_0000);
        advance("f_rst", 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
